stream_xbar_arbiter: RTL
========================

Name: stream_xbar_arbiter

Overview:
- Control plane for the streaming crossbar datapath (S_NUM sources x M_NUM outputs).
- Per output port, picks one requesting source by round-robin and locks that grant for a whole packet, up to the tlast beat.
- Drives the mux selects, s_ready and m_valid; the datapath only muxes data/last using grant_sel.

Parameters:
S_NUM, 5, number of source (input) streams, >=1
M_NUM, 3, number of output streams, >=1
SEL_W, max(1,$clog2(S_NUM)), width of one source index (derived localparam)
DEST_W, max(1,$clog2(M_NUM)), width of one destination field (derived localparam)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  S_NUM  per-source valid
s_last  in  S_NUM  per-source last-beat flag
s_dest  in  S_NUM*DEST_W  per-source destination; source i at [i*DEST_W +: DEST_W]
s_ready  out  S_NUM  per-source ready (combinational)
m_ready  in  M_NUM  per-output ready from downstream
m_valid  out  M_NUM  per-output valid (combinational)
grant_vld  out  M_NUM  output j currently owned by a source (registered)
grant_sel  out  M_NUM*SEL_W  owning source index per output; output j at [j*SEL_W +: SEL_W] (registered)
dest_err  out  S_NUM  1-cycle pulse per source presenting an out-of-range s_dest (registered)

Behaviour:
- Reset (async, rst_n=0): grant_vld=0, grant_sel=0, dest_err=0, every output FSM in IDLE, every rr pointer = S_NUM-1 (source 0 has first priority). Reset mid-packet drops the grant immediately; there is no packet resume.
- Request: req[j][i] = s_valid[i] && s_dest_i==j && s_dest_i<M_NUM && source i not owning any output.
- Per-output FSM, IDLE:
  - If any req[j], pick the first requesting i scanning ptr[j]+1, ptr[j]+2, ... modulo S_NUM.
  - Next edge: BUSY, grant_vld[j]=1, grant_sel[j]=i.
  - Grant latency is 1 cycle from first valid request.
- BUSY:
  - m_valid[j] = s_valid[sel].
  - s_ready[sel] = m_ready[j].
  - A beat transfers when both are 1.
  - If the transfer has s_last[sel]=1: at that edge go IDLE, grant_vld[j]=0, ptr[j]=sel.
  - Otherwise hold the grant, including while s_valid drops mid-packet.
- Inter-packet gap: after release, output j re-arbitrates in IDLE, so there is 1 bubble cycle between packets on the same output.
- Outputs and sources not addressed by any grant: s_ready=0, m_valid=0.
- Source rules:
  - s_dest must be stable from the first valid beat through the last beat; a source has at most one grant at a time.
  - A source with s_dest>=M_NUM is never granted and never receives s_ready. dest_err[i] pulses 1 on the cycle after each rising edge of that condition (valid && bad dest).
- Simultaneous events:
  - Different outputs arbitrate independently in the same cycle.
  - Several sources targeting the same output are resolved purely by the rr order.
  - A single-beat packet (s_last on the first beat) releases after 1 transfer.
- S_NUM=1: the arbiter degenerates to packet locking; grant_sel is always 0.

Test Plan:
- 5x3, all m_ready=1: sources 0,2,4 each send one 3-beat packet to output 1 from cycle 0 -> grants in order 0,2,4. grant_vld[1] high 3 cycles per packet with 1 idle cycle between. m_valid[1] beats = 9.
- 5x3: src1 ->out0 and src3 ->out2 simultaneously, 4 beats each -> both granted on the same cycle, concurrent transfer, no stall on either.
- Backpressure: src0 ->out1 4-beat packet, m_ready[1] toggles 1,0,1,0... -> s_ready[0] mirrors m_ready[1]. Grant holds until the 4th accepted beat with s_last, then grant_vld[1]=0 on the next cycle.
- Fairness: sources 0 and 1 stream back-to-back 1-beat packets to out0 -> grant_sel[0] alternates 0,1,0,1; neither starves.
- Bad dest: 3x5 configuration with S_NUM=3, M_NUM=5 gives DEST_W=3. src2 drives s_dest=6 with valid -> dest_err[2] pulses once, s_ready[2] stays 0, other sources unaffected.
- Reset mid-packet: rst_n=0 during beat 2 of a 5-beat packet -> grant_vld=0 asynchronously. After release, a new packet is granted from source 0 priority.

Source files
------------

// File: rtl/stream_xbar_arbiter_if.sv
// Handshake/control bundle between the crossbar datapath and its arbiter.
// slave = arbiter side, master = source/sink side driving requests and readies.
interface stream_xbar_arbiter_if #(
    parameter int S_NUM = 5,
    parameter int M_NUM = 3
);
    localparam int SEL_W  = (S_NUM > 1) ? $clog2(S_NUM) : 1;
    localparam int DEST_W = (M_NUM > 1) ? $clog2(M_NUM) : 1;

    logic [S_NUM-1:0]        s_valid;
    logic [S_NUM-1:0]        s_last;
    logic [S_NUM*DEST_W-1:0] s_dest;
    logic [S_NUM-1:0]        s_ready;
    logic [M_NUM-1:0]        m_ready;
    logic [M_NUM-1:0]        m_valid;
    logic [M_NUM-1:0]        grant_vld;
    logic [M_NUM*SEL_W-1:0]  grant_sel;
    logic [S_NUM-1:0]        dest_err;

    modport slave (
        input  s_valid, s_last, s_dest, m_ready,
        output s_ready, m_valid, grant_vld, grant_sel, dest_err
    );

    modport master (
        output s_valid, s_last, s_dest, m_ready,
        input  s_ready, m_valid, grant_vld, grant_sel, dest_err
    );
endinterface

// File: rtl/stream_xbar_arbiter.sv
// Per-output round-robin packet arbiter for an S_NUM x M_NUM stream crossbar.
// Grant 1 cycle after request, held to tlast; s_ready/m_valid pass straight through the grant.
module stream_xbar_arbiter #(
    parameter int S_NUM = 5,
    parameter int M_NUM = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stream_xbar_arbiter_if.slave bus
);
    localparam int SEL_W  = (S_NUM > 1) ? $clog2(S_NUM) : 1;
    localparam int DEST_W = (M_NUM > 1) ? $clog2(M_NUM) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                          state_q [M_NUM];
    state_t                          state_d [M_NUM];
    logic [M_NUM-1:0][SEL_W-1:0]     sel_q, sel_d;
    logic [M_NUM-1:0][SEL_W-1:0]     ptr_q, ptr_d;
    logic [M_NUM-1:0][S_NUM-1:0]     req;
    logic [S_NUM-1:0][DEST_W-1:0]    dest;
    logic [S_NUM-1:0]                owned, bad, bad_q, dest_err_q;
    logic [S_NUM-1:0]                s_ready_c;
    logic [M_NUM-1:0]                m_valid_c, grant_vld_c;

    assign dest = bus.s_dest;

    always_comb begin
        owned = '0;
        bad   = '0;
        req   = '0;
        for (int i = 0; i < S_NUM; i++) begin
            for (int j = 0; j < M_NUM; j++) begin
                if (state_q[j] == BUSY && sel_q[j] == SEL_W'(i)) begin
                    owned[i] = 1'b1;
                end
            end
            bad[i] = bus.s_valid[i] && (32'(dest[i]) >= 32'(M_NUM));
        end
        // An in-range match on j already excludes out-of-range destinations.
        for (int j = 0; j < M_NUM; j++) begin
            for (int i = 0; i < S_NUM; i++) begin
                req[j][i] = bus.s_valid[i] && (32'(dest[i]) == 32'(j)) && !owned[i];
            end
        end
    end

    always_comb begin
        logic             found;
        int               idx;
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        sel_d = sel_q;
        ptr_d = ptr_q;
        for (int j = 0; j < M_NUM; j++) begin
            state_d[j] = state_q[j];
            case (state_q[j])
                IDLE: begin
                    found = 1'b0;
                    // Scan starts just after the last winner so it has lowest priority.
                    for (int k = 1; k <= S_NUM; k++) begin
                        idx = int'(ptr_q[j]) + k;
                        if (idx >= S_NUM) idx = idx - S_NUM;
                        cand = SEL_W'(idx);
                        if (!found && req[j][cand]) begin
                            found    = 1'b1;
                            sel_d[j] = cand;
                        end
                    end
                    if (found) state_d[j] = BUSY;
                end
                BUSY: begin
                    if (bus.s_valid[sel_q[j]] && bus.m_ready[j] && bus.s_last[sel_q[j]]) begin
                        state_d[j] = IDLE;
                        ptr_d[j]   = sel_q[j];
                    end
                end
                default: state_d[j] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < M_NUM; j++) begin
                state_q[j] <= IDLE;
            end
            sel_q      <= '0;
            ptr_q      <= {M_NUM{SEL_W'(S_NUM - 1)}};
            bad_q      <= '0;
            dest_err_q <= '0;
        end else begin
            for (int j = 0; j < M_NUM; j++) begin
                state_q[j] <= state_d[j];
            end
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            bad_q      <= bad;
            dest_err_q <= bad & ~bad_q;
        end
    end

    always_comb begin
        m_valid_c   = '0;
        s_ready_c   = '0;
        grant_vld_c = '0;
        for (int j = 0; j < M_NUM; j++) begin
            if (state_q[j] == BUSY) begin
                grant_vld_c[j]        = 1'b1;
                m_valid_c[j]          = bus.s_valid[sel_q[j]];
                s_ready_c[sel_q[j]]   = bus.m_ready[j];
            end
        end
    end

    assign bus.s_ready   = s_ready_c;
    assign bus.m_valid   = m_valid_c;
    assign bus.grant_vld = grant_vld_c;
    assign bus.grant_sel = sel_q;
    assign bus.dest_err  = dest_err_q;
endmodule
